// File: rtl/bus_rv32_channel_bridge_pkg.sv
// Widths, bridge state encoding and constants shared by the rv32 channel bridge files.
package cpu_reg_package;

  localparam int address_width = 32;
  localparam int data_width    = 32;
  localparam int MAX_CH        = 16;

  localparam logic [data_width-1:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } bridge_state_t;

  // Channels sit on consecutive 256-byte windows starting at 0x9000.
  function automatic logic [MAX_CH-1:0][address_width-1:0] default_ch_base();
    logic [MAX_CH-1:0][address_width-1:0] bases;
    for (int k = 0; k < MAX_CH; k++) begin
      bases[k] = 32'h0000_9000 + 32'(k) * 32'h100;
    end
    return bases;
  endfunction

  localparam logic [MAX_CH-1:0][address_width-1:0] CH_BASE_DEFAULT = default_ch_base();

endpackage

// File: rtl/bus_rv32_addr_decode.sv
// Masked address compare against every channel base; the lowest matching channel wins.
module bus_rv32_addr_decode
  import cpu_reg_package::*;
#(
  parameter int NUM_CH = 4,
  parameter logic [MAX_CH-1:0][address_width-1:0] CH_BASE = CH_BASE_DEFAULT,
  parameter logic [address_width-1:0] CH_MASK = 32'hFFFF_FF00,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [address_width-1:0] address,
  output logic                     hit,
  output logic [IDX_W-1:0]         index
);

  // Scan from the top so a lower-numbered match overrides a higher one.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if ((address & CH_MASK) == CH_BASE[k]) begin
        hit   = 1'b1;
        index = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/bus_rv32_channel_bridge.sv
// Bridges single-cycle CPU access strobes onto one of NUM_CH busy-handshaked target channels,
// holding the CPU in halt until the channel finishes or the access times out.
module bus_rv32_channel_bridge
  import cpu_reg_package::*;
#(
  parameter int NUM_CH = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [MAX_CH-1:0][address_width-1:0] CH_BASE = CH_BASE_DEFAULT,
  parameter logic [address_width-1:0] CH_MASK = 32'hFFFF_FF00
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               req_i,
  input  logic [address_width-1:0]           address_i,
  input  logic [data_width-1:0]              data_i,
  input  logic                               we_i,
  input  logic [3:0]                         we_ram_i,
  output logic                               cpu_halt_o,
  output logic [data_width-1:0]              rdata_o,
  output logic                               rdata_valid_o,
  output logic                               miss_o,
  output logic                               err_o,
  output logic [NUM_CH-1:0]                  ch_valid_o,
  output logic [address_width-1:0]           ch_address_o,
  output logic [data_width-1:0]              ch_data_o,
  output logic                               ch_we_o,
  output logic [3:0]                         ch_be_o,
  input  logic [NUM_CH-1:0][data_width-1:0]  ch_rdata_i,
  input  logic [NUM_CH-1:0]                  ch_busy_i
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_t    state;
  logic [CNT_W-1:0] counter;
  logic [IDX_W-1:0] sel_idx;
  logic             halt_q;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  bus_rv32_addr_decode #(
    .NUM_CH (NUM_CH),
    .CH_BASE(CH_BASE),
    .CH_MASK(CH_MASK)
  ) u_decode (
    .address(address_i),
    .hit    (hit),
    .index  (hit_idx)
  );

  // The CPU must stall in the very cycle it strobes a hit, before the FSM has moved.
  assign cpu_halt_o = halt_q | ((state == IDLE) & req_i & hit);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      counter       <= '0;
      sel_idx       <= '0;
      halt_q        <= 1'b0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      miss_o        <= 1'b0;
      err_o         <= 1'b0;
      ch_valid_o    <= '0;
      ch_address_o  <= '0;
      ch_data_o     <= '0;
      ch_we_o       <= 1'b0;
      ch_be_o       <= '0;
    end else begin
      rdata_valid_o <= 1'b0;
      miss_o        <= 1'b0;
      ch_valid_o    <= '0;
      case (state)
        IDLE: begin
          if (req_i) begin
            if (hit) begin
              ch_address_o <= address_i;
              ch_data_o    <= data_i;
              ch_we_o      <= we_i;
              ch_be_o      <= we_ram_i;
              sel_idx      <= hit_idx;
              ch_valid_o   <= NUM_CH'(1) << hit_idx;
              halt_q       <= 1'b1;
              state        <= ISSUE;
            end else begin
              miss_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          counter <= '0;
          state   <= WAIT;
        end
        // Reaching the last count aborts even if busy drops in that same cycle.
        WAIT: begin
          if (counter == LAST_COUNT) begin
            if (!ch_we_o) begin
              rdata_o <= ERR_DATA;
            end
            err_o         <= 1'b1;
            halt_q        <= 1'b0;
            rdata_valid_o <= 1'b1;
            state         <= DONE;
          end else if (ch_busy_i[sel_idx]) begin
            counter <= counter + 1'b1;
          end else begin
            if (!ch_we_o) begin
              rdata_o <= ch_rdata_i[sel_idx];
            end
            halt_q        <= 1'b0;
            rdata_valid_o <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rv32_channel_bridge.sv
// Bench for the rv32 channel bridge: one long-timeout instance with overlapping ch0/ch3 windows
// and one eight-cycle-timeout instance, both checked against an access-level model.
module tb_bus_rv32_channel_bridge;

  localparam int NUM_CH = 4;
  localparam int TO_MAIN = 256;
  localparam int TO_SHORT = 8;
  localparam logic [31:0] MASK = 32'hFFFF_FF00;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  function automatic logic [15:0][31:0] make_bases(input bit overlap);
    logic [15:0][31:0] r;
    for (int k = 0; k < 16; k++) r[k] = 32'h9000 + 32'h100 * k;
    if (overlap) r[3] = 32'h9000;
    return r;
  endfunction

  localparam logic [15:0][31:0] BASES_MAIN = make_bases(1'b1);
  localparam logic [15:0][31:0] BASES_TO = make_bases(1'b0);

  logic clk;
  logic reset;
  logic req_main;
  logic req_to;
  logic [31:0] address;
  logic [31:0] data;
  logic we;
  logic [3:0] be;
  logic [NUM_CH-1:0][31:0] ch_rdata;
  logic [NUM_CH-1:0] ch_busy;

  logic m_halt, m_valid, m_miss, m_err, m_ch_we;
  logic [31:0] m_rdata, m_ch_address, m_ch_data;
  logic [NUM_CH-1:0] m_ch_valid;
  logic [3:0] m_ch_be;
  logic t_halt, t_valid, t_miss, t_err, t_ch_we;
  logic [31:0] t_rdata, t_ch_address, t_ch_data;
  logic [NUM_CH-1:0] t_ch_valid;
  logic [3:0] t_ch_be;

  bit sel_to;
  logic obs_halt, obs_valid, obs_miss, obs_err, obs_ch_we;
  logic [31:0] obs_rdata, obs_ch_address, obs_ch_data;
  logic [NUM_CH-1:0] obs_ch_valid;
  logic [3:0] obs_ch_be;

  int checks;
  int errors;
  logic [31:0] exp_rd_main;
  logic [31:0] exp_rd_to;
  bit exp_err_to;

  bus_rv32_channel_bridge #(
    .NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TO_MAIN), .CH_BASE(BASES_MAIN), .CH_MASK(MASK)
  ) dut_main (
    .clk_i(clk), .reset_i(reset), .req_i(req_main), .address_i(address), .data_i(data),
    .we_i(we), .we_ram_i(be), .cpu_halt_o(m_halt), .rdata_o(m_rdata), .rdata_valid_o(m_valid),
    .miss_o(m_miss), .err_o(m_err), .ch_valid_o(m_ch_valid), .ch_address_o(m_ch_address),
    .ch_data_o(m_ch_data), .ch_we_o(m_ch_we), .ch_be_o(m_ch_be), .ch_rdata_i(ch_rdata),
    .ch_busy_i(ch_busy)
  );

  bus_rv32_channel_bridge #(
    .NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TO_SHORT), .CH_BASE(BASES_TO), .CH_MASK(MASK)
  ) dut_to (
    .clk_i(clk), .reset_i(reset), .req_i(req_to), .address_i(address), .data_i(data),
    .we_i(we), .we_ram_i(be), .cpu_halt_o(t_halt), .rdata_o(t_rdata), .rdata_valid_o(t_valid),
    .miss_o(t_miss), .err_o(t_err), .ch_valid_o(t_ch_valid), .ch_address_o(t_ch_address),
    .ch_data_o(t_ch_data), .ch_we_o(t_ch_we), .ch_be_o(t_ch_be), .ch_rdata_i(ch_rdata),
    .ch_busy_i(ch_busy)
  );

  assign obs_halt       = sel_to ? t_halt : m_halt;
  assign obs_valid      = sel_to ? t_valid : m_valid;
  assign obs_miss       = sel_to ? t_miss : m_miss;
  assign obs_err        = sel_to ? t_err : m_err;
  assign obs_ch_we      = sel_to ? t_ch_we : m_ch_we;
  assign obs_rdata      = sel_to ? t_rdata : m_rdata;
  assign obs_ch_address = sel_to ? t_ch_address : m_ch_address;
  assign obs_ch_data    = sel_to ? t_ch_data : m_ch_data;
  assign obs_ch_valid   = sel_to ? t_ch_valid : m_ch_valid;
  assign obs_ch_be      = sel_to ? t_ch_be : m_ch_be;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no end of run, expected summary before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One CPU access: the model decides hit/channel, completion cycle and returned data from the
  // channel's busy length, then the observed cycle-by-cycle behaviour is compared against it.
  task automatic applyStimulus(input bit use_to, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic is_write, input logic [3:0] byte_en, input int busy_n);
    logic [15:0][31:0] bases;
    int limit, k, m, exp_cyc, vcyc, halt_cnt, pulses;
    bit hit, timed_out;
    logic [31:0] exp_rd;
    bases = use_to ? BASES_TO : BASES_MAIN;
    limit = use_to ? TO_SHORT : TO_MAIN;
    hit = 1'b0;
    k = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!hit && ((addr & MASK) == bases[i])) begin
        hit = 1'b1;
        k = i;
      end
    end
    for (int i = 0; i < NUM_CH; i++) ch_rdata[i] = $urandom;
    exp_rd = use_to ? exp_rd_to : exp_rd_main;
    sel_to = use_to;
    @(negedge clk);
    address = addr;
    data = wdata;
    we = is_write;
    be = byte_en;
    if (use_to) req_to = 1'b1;
    else req_main = 1'b1;
    #1;
    checkOutput("valid_low_idle", 64'(obs_valid), 64'(0));
    checkOutput("halt_on_req", 64'(obs_halt), 64'(hit));
    @(posedge clk);
    @(negedge clk);
    req_main = 1'b0;
    req_to = 1'b0;
    if (!hit) begin
      #1;
      checkOutput("miss_pulse", 64'(obs_miss), 64'(1));
      checkOutput("miss_no_halt", 64'(obs_halt), 64'(0));
      checkOutput("miss_no_ch_valid", 64'(obs_ch_valid), 64'(0));
      checkOutput("miss_rdata_kept", 64'(obs_rdata), 64'(exp_rd));
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("miss_one_cycle", 64'(obs_miss), 64'(0));
      return;
    end
    m = (busy_n > 1) ? busy_n : 1;
    timed_out = (m >= limit);
    exp_cyc = 2 + (timed_out ? limit : m);
    if (!is_write) exp_rd = timed_out ? DEAD : ch_rdata[k];
    if (use_to && timed_out) exp_err_to = 1'b1;
    halt_cnt = 1;
    pulses = 0;
    vcyc = 0;
    for (int c = 1; c <= 300 && vcyc == 0; c++) begin
      for (int i = 0; i < NUM_CH; i++) ch_busy[i] = (i == k) ? (c <= busy_n) : 1'($urandom);
      if (use_to) req_to = 1'($urandom);
      else req_main = 1'($urandom);
      #1;
      if (c == 1) begin
        checkOutput("ch_valid_onehot", 64'(obs_ch_valid), 64'(4'b0001 << k));
        checkOutput("ch_address", 64'(obs_ch_address), 64'(addr));
        checkOutput("ch_data", 64'(obs_ch_data), 64'(wdata));
        checkOutput("ch_we", 64'(obs_ch_we), 64'(is_write));
        checkOutput("ch_be", 64'(obs_ch_be), 64'(byte_en));
      end
      if (obs_ch_valid != '0) pulses++;
      if (obs_halt) halt_cnt++;
      if (obs_valid) vcyc = c;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    req_main = 1'b0;
    req_to = 1'b0;
    ch_busy = '0;
    checkOutput("valid_cycle", 64'(vcyc), 64'(exp_cyc));
    checkOutput("halt_cycles", 64'(halt_cnt), 64'(exp_cyc));
    checkOutput("ch_valid_pulses", 64'(pulses), 64'(1));
    checkOutput("rdata", 64'(obs_rdata), 64'(exp_rd));
    checkOutput("err", 64'(obs_err), 64'(use_to ? exp_err_to : 1'b0));
    checkOutput("ch_address_held", 64'(obs_ch_address), 64'(addr));
    if (use_to) exp_rd_to = exp_rd;
    else exp_rd_main = exp_rd;
  endtask

  initial begin
    int valid_seen;
    logic [31:0] rnd_addr;
    checks = 0;
    errors = 0;
    exp_rd_main = '0;
    exp_rd_to = '0;
    exp_err_to = 1'b0;
    sel_to = 1'b0;
    reset = 1'b1;
    req_main = 1'b0;
    req_to = 1'b0;
    address = '0;
    data = '0;
    we = 1'b0;
    be = '0;
    ch_rdata = '0;
    ch_busy = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_halt", 64'(m_halt), 64'(0));
    checkOutput("reset_rdata", 64'(m_rdata), 64'(0));
    checkOutput("reset_valid", 64'(m_valid), 64'(0));
    checkOutput("reset_miss", 64'(m_miss), 64'(0));
    checkOutput("reset_err", 64'(m_err), 64'(0));
    checkOutput("reset_ch_valid", 64'(m_ch_valid), 64'(0));
    checkOutput("reset_ch_address", 64'(m_ch_address), 64'(0));
    checkOutput("reset_ch_be", 64'(m_ch_be), 64'(0));
    checkOutput("reset_err_to", 64'(t_err), 64'(0));

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 32'h0000_9104, 32'h0, 1'b0, 4'hF, 0);
    applyStimulus(1'b0, 32'h0000_9208, 32'h1234_5678, 1'b1, 4'b0011, 10);
    applyStimulus(1'b0, 32'h0000_8000, 32'h0, 1'b0, 4'hF, 0);
    applyStimulus(1'b0, 32'h0000_9010, 32'h0, 1'b0, 4'hF, 2);
    applyStimulus(1'b0, 32'h0000_9304, 32'h0, 1'b0, 4'hF, 1);

    $display("[TB] random accesses");
    for (int n = 0; n < 24; n++) begin
      rnd_addr = 32'h0000_9000 + 32'($urandom_range(0, 32'h4FF));
      applyStimulus(1'b0, rnd_addr, $urandom, 1'($urandom), 4'($urandom), int'($urandom_range(0, 12)));
    end

    $display("[TB] timeout accesses");
    applyStimulus(1'b1, 32'h0000_9304, 32'h0, 1'b0, 4'hF, 7);
    checkOutput("err_clear_below_limit", 64'(t_err), 64'(0));
    applyStimulus(1'b1, 32'h0000_9100, 32'h0, 1'b0, 4'hF, 1000);
    applyStimulus(1'b1, 32'h0000_9004, 32'h0, 1'b0, 4'hF, 0);
    applyStimulus(1'b1, 32'h0000_9200, 32'hCAFE_0001, 1'b1, 4'hF, 3);
    checkOutput("err_sticky", 64'(t_err), 64'(1));

    $display("[TB] reset during wait");
    sel_to = 1'b0;
    @(negedge clk);
    address = 32'h0000_9004;
    we = 1'b0;
    be = 4'hF;
    req_main = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_main = 1'b0;
    ch_busy = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("halt_before_reset", 64'(m_halt), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ch_busy = '0;
    #1;
    exp_rd_main = '0;
    exp_rd_to = '0;
    exp_err_to = 1'b0;
    checkOutput("abort_halt", 64'(m_halt), 64'(0));
    checkOutput("abort_rdata", 64'(m_rdata), 64'(0));
    checkOutput("abort_ch_valid", 64'(m_ch_valid), 64'(0));
    checkOutput("abort_ch_address", 64'(m_ch_address), 64'(0));
    checkOutput("abort_ch_we", 64'(m_ch_we), 64'(0));
    checkOutput("abort_err_to", 64'(t_err), 64'(0));
    valid_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_valid) valid_seen++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    checkOutput("abort_no_valid", 64'(valid_seen), 64'(0));
    applyStimulus(1'b0, 32'h0000_9104, 32'h0, 1'b0, 4'hF, 4);
    applyStimulus(1'b1, 32'h0000_9300, 32'h0, 1'b0, 4'hF, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rv32_channel_bridge.md
BUS_RV32_CHANNEL_BRIDGE -- requirements
Module: bus_rv32_channel_bridge

Interface
REQ-001 Parameter NUM_CH, default 4, number of target channels (1..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 256, maximum WAIT cycles before an access is aborted (2..65535).
REQ-003 Parameter CH_BASE, default {32'h0000_9000 + k*32'h100}, per-channel base address array.
REQ-004 Parameter CH_MASK, default 32'hFFFF_FF00, address compare mask applied to every channel.
REQ-005 clk_i  in  1  single system clock; all logic rising-edge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 req_i  in  1  CPU access strobe, one cycle per access.
REQ-008 address_i  in  address_width  CPU byte address.
REQ-009 data_i  in  data_width  CPU write data.
REQ-010 we_i  in  1  1 = write, 0 = read.
REQ-011 we_ram_i  in  4  byte enables.
REQ-012 cpu_halt_o  out  1  stalls CPU while an access is outstanding.
REQ-013 rdata_o  out  data_width  read data returned to CPU.
REQ-014 rdata_valid_o  out  1  one-cycle completion pulse.
REQ-015 miss_o  out  1  one-cycle pulse, request hit no channel.
REQ-016 err_o  out  1  sticky timeout flag.
REQ-017 ch_valid_o  out  NUM_CH  one-hot, one-cycle command strobe per channel.
REQ-018 ch_address_o / ch_data_o / ch_we_o / ch_be_o  out  address_width / data_width / 1 / 4  shared latched command fields.
REQ-019 ch_rdata_i  in  NUM_CH x data_width  per-channel read data.
REQ-020 ch_busy_i  in  NUM_CH  per-channel module busy.

Function
REQ-021 Hit for channel k SHALL be (address_i & CH_MASK) == CH_BASE[k]; multiple hits resolve to lowest k.
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-023 IDLE with req_i and hit: latch address/data/we/be and k, go ISSUE; cpu_halt_o SHALL be 1 combinationally in that same cycle.
REQ-024 IDLE with req_i and no hit: miss_o pulses next cycle, no halt, state stays IDLE, rdata_o unchanged.
REQ-025 ISSUE: ch_valid_o[k] = 1 for exactly one cycle, cpu_halt_o = 1, go WAIT, timeout counter cleared.
REQ-026 WAIT: cpu_halt_o = 1; ch_busy_i[k] = 1 stays WAIT and increments counter; ch_busy_i[k] = 0 captures ch_rdata_i[k] into rdata_o (reads only) and goes DONE.
REQ-027 WAIT with counter == TIMEOUT_CYCLES-1 and busy still 1: rdata_o = ERR_DATA (32'hDEAD_BEEF) for reads, err_o set, go DONE; timeout wins over simultaneous busy release.
REQ-028 DONE: cpu_halt_o = 0, rdata_valid_o = 1, go IDLE; writes leave rdata_o unchanged.
REQ-029 Minimum access latency SHALL be 3 cycles from req_i to rdata_valid_o (busy low in first WAIT cycle).
REQ-030 req_i outside IDLE SHALL be ignored.
REQ-031 Busy of non-selected channels SHALL have no effect.
REQ-032 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); no wrap-around possible.

Reset
REQ-033 On reset_i: state IDLE, counter 0, all outputs 0 (rdata_o, err_o, ch_valid_o, latched command fields included).
REQ-034 Reset mid-transaction SHALL abort the access with no rdata_valid_o pulse; ch_valid_o low from the next edge.
REQ-035 err_o SHALL clear only on reset.

Structure
REQ-036 address_width, data_width, bridge state enum and ERR_DATA SHALL live in cpu_reg_package.
REQ-037 Hit decode and priority encode SHALL be sub-module bus_rv32_addr_decode (parametrised NUM_CH, outputs hit and index).

Verification
REQ-038 Read ch1 (addr 0x9104), busy low -> ch_valid_o = 4'b0010 once, rdata_o = ch_rdata_i[1], rdata_valid_o 3 cycles after req_i.
REQ-039 Write ch2, data 0x1234_5678, be 4'b0011, busy held 10 cycles -> halt high 12 cycles, ch_be_o = 4'b0011, rdata_o unchanged.
REQ-040 Read addr 0x8000 -> miss_o pulse, cpu_halt_o never high, no ch_valid_o.
REQ-041 TIMEOUT_CYCLES = 8, busy stuck -> rdata_o = 32'hDEAD_BEEF, err_o = 1 sticky, halt released.
REQ-042 reset_i during WAIT -> no rdata_valid_o, all outputs 0 next cycle, next access completes normally.
REQ-043 Overlapping CH_BASE for ch0/ch3 -> ch0 selected.
